templatized_alu_sequencer: RTL

Issue-side sequencer for the templatized ALU. It accepts one operation per request handshake and drives `op_code` into `templatized_alu_control`. It samples the returned 3-bit unit enable, pulses start to the enabled functional units and waits for their done strobes, with a timeout. It then returns the result, or an error for illegal/timed-out ops, over a valid/ready response channel. The block sits between the instruction front end and the three functional units.

---
 rtl/templatized_alu_sequencer.sv | 113 +++++++++++
 1 files changed

// File: rtl/templatized_alu_sequencer.sv
// templatized_alu_sequencer: issues one op at a time to the enabled functional units,
// collects their done strobes with a timeout and returns result/error on a valid/ready channel.
module templatized_alu_sequencer #(
    parameter int WIDTH   = 32,
    parameter int TIMEOUT = 15
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [3:0]           req_op,
    input  logic [WIDTH-1:0]     req_a,
    input  logic [WIDTH-1:0]     req_b,
    output logic [3:0]           op_code,
    input  logic [2:0]           en,
    output logic [2:0]           unit_start,
    output logic [WIDTH-1:0]     unit_a,
    output logic [WIDTH-1:0]     unit_b,
    input  logic [2:0]           unit_done,
    input  logic [3*WIDTH-1:0]   unit_result,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [WIDTH-1:0]     rsp_data,
    output logic                 rsp_err
);
    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {IDLE, DECODE, ISSUE, WAIT, RESP} state_t;
    state_t state, state_n;

    logic [3:0]       op_q;
    logic [WIDTH-1:0] a_q, b_q, res_q, sel_res;
    logic [2:0]       en_q, done_q, done_now;
    logic [CW-1:0]    wait_cnt;
    logic             sel_done, complete, expired;

    assign op_code    = op_q;
    assign unit_a     = a_q;
    assign unit_b     = b_q;
    assign req_ready  = state == IDLE;
    assign rsp_valid  = state == RESP;
    assign unit_start = state == ISSUE ? en_q : 3'b000;

    // The reported result comes from the lowest-index enabled unit.
    always_comb begin
        done_now = unit_done & en_q;
        sel_done = en_q[0] ? done_now[0] : en_q[1] ? done_now[1] : done_now[2];
        sel_res  = en_q[0] ? unit_result[0 +: WIDTH] :
                   en_q[1] ? unit_result[WIDTH +: WIDTH] : unit_result[2*WIDTH +: WIDTH];
        complete = (done_q | done_now) == en_q;
        expired  = wait_cnt == CW'(TIMEOUT - 1);
        state_n  = state;
        case (state)
            IDLE:    state_n = req_valid ? DECODE : IDLE;
            DECODE:  state_n = en == 3'b000 ? RESP : ISSUE;
            ISSUE:   state_n = WAIT;
            WAIT:    state_n = complete || expired ? RESP : WAIT;
            RESP:    state_n = rsp_ready ? IDLE : RESP;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            en_q     <= '0;
            done_q   <= '0;
            wait_cnt <= '0;
            res_q    <= '0;
            rsp_data <= '0;
            rsp_err  <= 1'b0;
        end else begin
            case (state)
                IDLE: if (req_valid) begin
                    op_q <= req_op;
                    a_q  <= req_a;
                    b_q  <= req_b;
                end
                DECODE: begin
                    en_q     <= en;
                    done_q   <= '0;
                    wait_cnt <= '0;
                    res_q    <= '0;
                    rsp_data <= '0;
                    rsp_err  <= en == 3'b000;
                end
                WAIT: begin
                    done_q <= done_q | done_now;
                    if (sel_done) res_q <= sel_res;
                    // Completion takes priority over a coincident timeout.
                    if (complete) begin
                        rsp_err  <= 1'b0;
                        rsp_data <= sel_done ? sel_res : res_q;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                        if (expired) begin
                            rsp_err  <= 1'b1;
                            rsp_data <= '0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end
endmodule
